// File: rtl/led_seq_pkg.sv
// Shared types and defaults for the LED scene sequencer.
// Optional feature macro: LED_SEQ_LOOP_EN (see led_scene_sequencer.sv).
package led_seq_pkg;

  localparam int N_SCENES_DEF = 8;
  localparam int TICK_DIV_DEF = 100000;
  localparam int LVL_W_DEF    = 15;
  localparam int DWELL_W      = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DWELL = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // One scene table record at the default intensity width.
  typedef struct packed {
    logic [LVL_W_DEF-1:0] red;
    logic [LVL_W_DEF-1:0] green;
    logic [LVL_W_DEF-1:0] blue;
    logic [2:0]           toggle;
    logic [DWELL_W-1:0]   dwell;
  } scene_t;

  // A programmed dwell of zero still shows the scene for one tick.
  function automatic logic [DWELL_W-1:0] dwell_eff(input logic [DWELL_W-1:0] d);
    return (d == '0) ? DWELL_W'(1) : d;
  endfunction

endpackage

// File: rtl/led_seq_tick.sv
// Dwell tick prescaler: counts 0..TICK_DIV-1 while not cleared and
// emits a one-cycle tick on the terminal count.
module led_seq_tick #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = !clr && (cnt == LAST);

  // Prescaler count: restarts on clear and wraps after the terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/led_scene_sequencer.sv
// Scene sequencer for the board LED datapath: steps through a table of
// RGB/toggle/dwell scenes and drives the LED controller inputs.
// Optional feature macro: LED_SEQ_LOOP_EN -- when defined, loop_en wraps
// the run back to scene 0 after last_idx; when undefined every run is
// one-shot and loop_en is ignored.
module led_scene_sequencer
  import led_seq_pkg::*;
#(
  parameter int N_SCENES = N_SCENES_DEF,
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int LVL_W    = LVL_W_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        run,
  input  logic                        loop_en,
  input  logic [$clog2(N_SCENES)-1:0] last_idx,
  input  logic                        wr_en,
  input  logic [$clog2(N_SCENES)-1:0] wr_addr,
  input  logic [LVL_W-1:0]            wr_red,
  input  logic [LVL_W-1:0]            wr_green,
  input  logic [LVL_W-1:0]            wr_blue,
  input  logic [2:0]                  wr_toggle,
  input  logic [DWELL_W-1:0]          wr_dwell,
  output logic [LVL_W-1:0]            red,
  output logic [LVL_W-1:0]            green,
  output logic [LVL_W-1:0]            blue,
  output logic [2:0]                  led_toggle,
  output logic [$clog2(N_SCENES)-1:0] scene_idx,
  output logic                        busy,
  output logic                        done
);

  localparam int IDX_W = $clog2(N_SCENES);

  // Scene table, one array per field, held in plain registers.
  logic [LVL_W-1:0]   tbl_red    [N_SCENES];
  logic [LVL_W-1:0]   tbl_green  [N_SCENES];
  logic [LVL_W-1:0]   tbl_blue   [N_SCENES];
  logic [2:0]         tbl_toggle [N_SCENES];
  logic [DWELL_W-1:0] tbl_dwell  [N_SCENES];

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [DWELL_W-1:0] dwell_cnt;
  logic               tick;
  logic               wrap;

`ifdef LED_SEQ_LOOP_EN
  assign wrap = loop_en && (idx == last_idx);
`else
  logic unused_loop_en;
  assign unused_loop_en = loop_en;
  assign wrap = 1'b0;
`endif

  // The prescaler only runs while a scene is dwelling; LOAD restarts it.
  led_seq_tick #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state != DWELL),
    .tick  (tick)
  );

  // Table writes: accepted in every state; a LOAD on the same edge sees the old entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_SCENES; i++) begin
        tbl_red[i]    <= '0;
        tbl_green[i]  <= '0;
        tbl_blue[i]   <= '0;
        tbl_toggle[i] <= '0;
        tbl_dwell[i]  <= '0;
      end
    end else if (wr_en) begin
      tbl_red[wr_addr]    <= wr_red;
      tbl_green[wr_addr]  <= wr_green;
      tbl_blue[wr_addr]   <= wr_blue;
      tbl_toggle[wr_addr] <= wr_toggle;
      tbl_dwell[wr_addr]  <= wr_dwell;
    end
  end

  // Sequencer FSM with registered outputs; dropping run aborts from any state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      dwell_cnt  <= '0;
      red        <= '0;
      green      <= '0;
      blue       <= '0;
      led_toggle <= '0;
      scene_idx  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!run) begin
        state      <= IDLE;
        idx        <= '0;
        red        <= '0;
        green      <= '0;
        blue       <= '0;
        led_toggle <= '0;
        scene_idx  <= '0;
        busy       <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state <= LOAD;
            idx   <= '0;
            busy  <= 1'b1;
          end
          LOAD: begin
            red        <= tbl_red[idx];
            green      <= tbl_green[idx];
            blue       <= tbl_blue[idx];
            led_toggle <= tbl_toggle[idx];
            scene_idx  <= idx;
            dwell_cnt  <= dwell_eff(tbl_dwell[idx]);
            state      <= DWELL;
          end
          DWELL: begin
            if (tick) begin
              // Expiry is decided on the tick that would take the count to zero.
              if (dwell_cnt == DWELL_W'(1)) begin
                if (idx < last_idx) begin
                  idx   <= idx + IDX_W'(1);
                  state <= LOAD;
                end else if (wrap) begin
                  idx   <= '0;
                  state <= LOAD;
                end else begin
                  state <= HOLD;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                end
              end else begin
                dwell_cnt <= dwell_cnt - DWELL_W'(1);
              end
            end
          end
          HOLD: begin
            // Last scene stays displayed until run is released.
            state <= HOLD;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/led_scene_sequencer.md
# led_scene_sequencer

Programmable scene sequencer for the board LED datapath. It holds a small table of "scenes", each with RGB intensities, an LED toggle mask and a dwell time. It steps through the table and drives the level and toggle inputs of the RGB LED controllers and the LED gating. It sits between the xDOM register interface, which loads scenes and starts/stops runs, and the existing rgb_led_ctrl / toggle-gating logic in the top level.

## Interface
Parameters:
- N_SCENES, 8, scene table depth (power of two, 2..16)
- TICK_DIV, 100000, lclk cycles per dwell tick (1 ms at 100 MHz)
- LVL_W, 15, RGB intensity width

Ports:
- clk  in  1  logic clock (100 MHz lclk)
- rst_n  in  1  reset, asynchronous, active-low
- run  in  1  level; high = sequence enabled, low = abort/idle
- loop_en  in  1  high = wrap to scene 0 after last scene
- last_idx  in  log2(N_SCENES)  index of final scene in the run
- wr_en  in  1  scene table write strobe
- wr_addr  in  log2(N_SCENES)  scene index to write
- wr_red / wr_green / wr_blue  in  LVL_W each  scene intensities
- wr_toggle  in  3  scene LED toggle mask (bit meanings as xDOM 12'h8ff)
- wr_dwell  in  16  scene dwell in ticks
- red / green / blue  out  LVL_W each  current scene levels
- led_toggle  out  3  current scene toggle mask
- scene_idx  out  log2(N_SCENES)  index of displayed scene
- busy  out  1  high in LOAD or DWELL
- done  out  1  one-cycle pulse on one-shot completion

## Operation
- States: IDLE, LOAD, DWELL, HOLD.
- IDLE: red/green/blue/led_toggle/scene_idx = 0, busy = 0. run = 1 → LOAD with idx = 0.
- LOAD (1 cycle): register table[idx] into the outputs; scene_idx = idx; load dwell counter with max(dwell, 1); clear tick prescaler → DWELL.
- DWELL: the prescaler counts 0..TICK_DIV-1; at terminal count the dwell counter decrements. When the counter reaches 0:
  - idx < last_idx → idx+1, LOAD.
  - idx == last_idx with loop_en → idx = 0, LOAD.
  - Otherwise → HOLD, and done pulses that cycle.
- HOLD: outputs keep the last scene; busy = 0. run = 0 → IDLE. A new run requires run low then high.
- run = 0 in any state → IDLE on the next edge; outputs clear on that edge; no done pulse.
- last_idx ≥ N_SCENES is impossible by width. last_idx is sampled on each scene expiry. Changing it mid-run takes effect at the next expiry.
- Table writes are accepted in every state.
  - A write does not alter the outputs of the scene currently displayed; the new value is seen on the next LOAD of that index.
  - A write and a LOAD to the same index on the same edge: LOAD gets the old contents (read-first).
- Table reset contents: all zero (dwell 0 → 1 tick).
- Dwell arithmetic: 16-bit unsigned; dwell 0 behaves as 1. Prescaler width is ceil(log2(TICK_DIV)).

## Timing
- run sampled high in IDLE at edge k → LOAD at k+1 → outputs valid after edge k+2; busy rises after edge k+1.
- Scene n output update to scene n+1 update: max(dwell,1)·TICK_DIV + 1 cycles.
- done is asserted for the single cycle after the edge entering HOLD.
- Reset: all outputs 0, state IDLE, table cleared, asynchronously on rst_n low; leaving reset synchronously on release.

## Configuration
- LED_SEQ_LOOP_EN defined: loop_en honoured as above.
- Not defined: loop_en is ignored. Every run is one-shot, ending in HOLD with done, and the wrap logic is not synthesised.

## Structure
- Package led_seq_pkg:
  - state enum
  - scene record type (red, green, blue, toggle, dwell)
  - default N_SCENES / TICK_DIV / LVL_W constants
  - DWELL_W = 16
- One sub-module, led_seq_tick: prescaler with synchronous clear, emitting a one-cycle tick every TICK_DIV cycles.
- Scene table is registers inside led_scene_sequencer; no RAM primitive.

## Test plan
Benches use TICK_DIV = 4.
- Reset with run high: outputs all 0, state IDLE, busy 0 until rst_n releases; LOAD follows the first edge after release.
- Load scenes 0..2 (dwells 2, 1, 3), last_idx = 2, loop off, run high → outputs change at 9-cycle, then 5-cycle, then 13-cycle spacing. done pulses once, and scene 2 levels are held.
- Same scenes with loop_en = 1 (LED_SEQ_LOOP_EN defined) → scene_idx sequence 0,1,2,0,1 and no done. Without the macro → identical to the one-shot case.
- Scene with dwell = 0 → displayed for exactly 4 DWELL cycles (same as dwell 1).
- run dropped mid-DWELL of scene 1 → all outputs 0 and busy 0 one edge later, no done. Re-raising run restarts at scene 0.
- Write scene 1 red = 15'h1234 on the same edge scene 1 LOADs (old red 15'h0100) → displays 15'h0100. The next loop pass displays 15'h1234.
